// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the IF/LS memory arbiter: port ids and default geometry.
package mem_arbiter_pkg;

    localparam int ARB_ADDR_W    = 10;
    localparam int ARB_DATA_W    = 32;
    localparam int ARB_MEM_WORDS = 32;

    // Port ids double as bit positions in the grant vector and pointer values.
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; ptr holds the port granted last, which loses a tie.
import mem_arbiter_pkg::*;

module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       ptr_nxt
);

    always_comb begin
        gnt     = 2'b00;
        ptr_nxt = ptr;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (ptr == PORT_LS) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        if (gnt[PORT_LS])
            ptr_nxt = PORT_LS;
        else if (gnt[PORT_IF])
            ptr_nxt = PORT_IF;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, one access
// per cycle, registered read data returned with a one-cycle valid pulse.
import mem_arbiter_pkg::*;

module mem_arbiter #(
    parameter int ADDR_W    = ARB_ADDR_W,
    parameter int DATA_W    = ARB_DATA_W,
    parameter int MEM_WORDS = ARB_MEM_WORDS
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_rvalid,
    output logic              if_err,

    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_rvalid,
    output logic              ls_err,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    logic [1:0]        gnt_raw, gnt;
    logic              ptr_q, ptr_nxt;
    logic              any_gnt, oor;
    logic [ADDR_W-1:0] sel_addr, addr_q;
    logic [DATA_W-1:0] din_q;

    rr_arb2 u_arb (
        .req     ({ls_req, if_req}),
        .ptr     (ptr_q),
        .gnt     (gnt_raw),
        .ptr_nxt (ptr_nxt)
    );

    // Nothing is granted while reset is held, so a reset-cycle request has no effect.
    assign gnt     = reset ? 2'b00 : gnt_raw;
    assign any_gnt = |gnt;
    assign if_ack  = gnt[PORT_IF];
    assign ls_ack  = gnt[PORT_LS];

    assign sel_addr = gnt[PORT_LS] ? ls_addr : if_addr;
    assign oor      = (sel_addr >= ADDR_W'(MEM_WORDS));

    // Idle cycles replay the last driven address/data to keep the memory bus quiet.
    assign mem_addr = any_gnt ? sel_addr : addr_q;
    assign mem_din  = any_gnt ? ls_wdata : din_q;
    assign mem_we   = gnt[PORT_LS] & ls_we & ~oor;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q     <= PORT_LS;
            addr_q    <= '0;
            din_q     <= '0;
            if_rvalid <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            ls_rvalid <= 1'b0;
            ls_err    <= 1'b0;
            ls_rdata  <= '0;
        end else begin
            if (any_gnt) begin
                ptr_q  <= ptr_nxt;
                addr_q <= sel_addr;
                din_q  <= ls_wdata;
            end
            if_rvalid <= gnt[PORT_IF];
            if_err    <= gnt[PORT_IF] & oor;
            if (gnt[PORT_IF] && !oor)
                if_rdata <= mem_dout;
            ls_rvalid <= gnt[PORT_LS];
            ls_err    <= gnt[PORT_LS] & oor;
            // Stores and out-of-range accesses leave the load register untouched.
            if (gnt[PORT_LS] && !oor && !ls_we)
                ls_rdata <= mem_dout;
        end
    end

endmodule
